// File: rtl/pix_line_buffer.sv
// Ping-pong line buffer: captures aligner pixel lines into two banks and replays them on a valid/ready stream.
// Optional build macro PIX_TEST_PATTERN_EN stores the write address instead of din (bring-up pattern).
module pix_line_buffer #(
  parameter int LINE_PIX = 512,
  parameter int AW       = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        line_start,
  input  logic        wr,
  input  logic [11:0] din,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [11:0] m_data,
  output logic        m_last,
  output logic [15:0] line_cnt,
  output logic [7:0]  ovf_cnt,
  output logic        overflow,
  output logic        short_err
);

  typedef enum logic [1:0] {W_WAIT, W_FILL, W_DROP} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_PREFETCH, R_STREAM} rstate_e;

  localparam logic [AW-1:0] LAST = AW'(LINE_PIX - 1);

  wstate_e       wstate_q, wstate_d, ws;
  rstate_e       rstate_q, rstate_d;
  logic [AW-1:0] wptr_q, wptr_d, waddr;
  logic [AW-1:0] rptr_q, rptr_d, raddr;
  logic          wbank_q, wbank_d, rbank_q, rbank_d;
  logic [1:0]    full_q, full_d;
  logic [11:0]   rdata_q, wdata;
  logic [15:0]   line_cnt_q, line_cnt_d;
  logic [7:0]    ovf_cnt_q, ovf_cnt_d;
  logic          overflow_q, overflow_d;
  logic          short_err_q, short_err_d;
  logic          we, rd_en, free_now, bank_free;

  logic [11:0]   mem [2*LINE_PIX];

  // The reader's bank release in this very cycle lets the writer reuse that bank.
  assign bank_free = ~full_q[wbank_q] | (free_now & (rbank_q == wbank_q));

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    rstate_d   = rstate_q;
    rptr_d     = rptr_q;
    rbank_d    = rbank_q;
    line_cnt_d = line_cnt_q;
    rd_en      = 1'b0;
    raddr      = rptr_q;
    free_now   = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        if (full_q[rbank_q]) begin
          rd_en    = 1'b1;
          raddr    = '0;
          rptr_d   = '0;
          rstate_d = R_PREFETCH;
        end
      end
      R_PREFETCH: rstate_d = R_STREAM;
      R_STREAM: begin
        if (m_ready) begin
          if (rptr_q == LAST) begin
            free_now   = 1'b1;
            rbank_d    = ~rbank_q;
            line_cnt_d = line_cnt_q + 16'd1;
            rstate_d   = R_IDLE;
          end else begin
            // Fetch the next word on acceptance so continuous ready streams without bubbles.
            rptr_d = rptr_q + AW'(1);
            raddr  = rptr_q + AW'(1);
            rd_en  = 1'b1;
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_comb begin
    wstate_d    = wstate_q;
    wptr_d      = wptr_q;
    wbank_d     = wbank_q;
    full_d      = full_q;
    ovf_cnt_d   = ovf_cnt_q;
    overflow_d  = overflow_q;
    short_err_d = 1'b0;
    we          = 1'b0;
    waddr       = wptr_q;
    ws          = wstate_q;
    if (line_start) begin
      short_err_d = (wstate_q == W_FILL) && (wptr_q != '0);
      waddr       = '0;
      wptr_d      = '0;
      if (bank_free) begin
        ws = W_FILL;
      end else begin
        ws         = W_DROP;
        overflow_d = 1'b1;
        if (ovf_cnt_q != 8'hFF) ovf_cnt_d = ovf_cnt_q + 8'd1;
      end
      wstate_d = ws;
    end
    if (wr && ws == W_FILL) begin
      we     = 1'b1;
      wptr_d = waddr + AW'(1);
      if (waddr == LAST) begin
        full_d[wbank_q] = 1'b1;
        wbank_d         = ~wbank_q;
        wstate_d        = W_WAIT;
      end
    end
    if (free_now) full_d[rbank_q] = 1'b0;
`ifdef PIX_TEST_PATTERN_EN
    wdata = 12'(waddr);
`else
    wdata = din;
`endif
  end

  // NOTE: the pixel array has no reset; bank FULL flags, not memory contents, decide what is valid.
  always_ff @(posedge clk) begin
    if (we) mem[{wbank_q, waddr}] <= wdata;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wstate_q    <= W_WAIT;
      rstate_q    <= R_IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      wbank_q     <= 1'b0;
      rbank_q     <= 1'b0;
      full_q      <= '0;
      rdata_q     <= '0;
      line_cnt_q  <= '0;
      ovf_cnt_q   <= '0;
      overflow_q  <= 1'b0;
      short_err_q <= 1'b0;
    end else begin
      wstate_q    <= wstate_d;
      rstate_q    <= rstate_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      wbank_q     <= wbank_d;
      rbank_q     <= rbank_d;
      full_q      <= full_d;
      line_cnt_q  <= line_cnt_d;
      ovf_cnt_q   <= ovf_cnt_d;
      overflow_q  <= overflow_d;
      short_err_q <= short_err_d;
      if (rd_en) rdata_q <= mem[{rbank_q, raddr}];
    end
  end

  assign m_valid   = (rstate_q == R_STREAM);
  assign m_last    = m_valid && (rptr_q == LAST);
  assign m_data    = rdata_q;
  assign line_cnt  = line_cnt_q;
  assign ovf_cnt   = ovf_cnt_q;
  assign overflow  = overflow_q;
  assign short_err = short_err_q;

endmodule

// File: tb/tb_pix_line_buffer.sv
// Directed self-checking bench for pix_line_buffer (default build, LINE_PIX=512).
module tb_pix_line_buffer;

  localparam int LP = 512;

  logic        clk = 1'b0;
  logic        reset, line_start, wr, m_ready;
  logic [11:0] din, m_data;
  logic        m_valid, m_last, overflow, short_err;
  logic [15:0] line_cnt;
  logic [7:0]  ovf_cnt;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          short_cnt = 0;
  logic [12:0] beats[$];

  always #5 clk = ~clk;

  pix_line_buffer #(.LINE_PIX(LP), .AW(9)) dut (
    .clk(clk), .reset(reset), .line_start(line_start), .wr(wr), .din(din),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .line_cnt(line_cnt), .ovf_cnt(ovf_cnt), .overflow(overflow), .short_err(short_err)
  );

  // Accepted beats and short_err pulses are recorded on the falling edge.
  always @(negedge clk) begin
    if (m_valid && m_ready) beats.push_back({m_last, m_data});
    if (short_err) short_cnt++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; line_start = 1'b0; wr = 1'b0; din = '0; m_ready = 1'b0;
    tick; tick;
    reset = 1'b0;
    beats.delete();
    short_cnt = 0;
    tick;
  endtask

  // One pixel every two cycles; returns just after the edge that captured the last pixel.
  task automatic send_line(input int n, input logic [11:0] base, input bit merge);
    line_start = 1'b1;
    if (merge) begin wr = 1'b1; din = base; end
    tick;
    line_start = 1'b0; wr = 1'b0;
    for (int i = (merge ? 1 : 0); i < n; i++) begin
      tick;
      wr = 1'b1; din = base + 12'(i);
      tick;
      wr = 1'b0;
    end
  endtask

  task automatic wait_beats(input int n, input int budget, input string name);
    int c = 0;
    while (beats.size() < n && c < budget) begin tick; c++; end
    n_checks++;
    if (beats.size() < n) begin
      n_fail++;
      $display("FAIL %s: got %0d beats, required %0d", name, beats.size(), n);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; line_start = 1'b0; wr = 1'b0; din = '0; m_ready = 1'b0;
    #3;
    n_checks++;
    if ({m_valid, m_data, m_last, line_cnt, ovf_cnt, overflow, short_err} !== 39'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b d=%h l=%b lc=%0d oc=%0d of=%b se=%b, required all 0",
               m_valid, m_data, m_last, line_cnt, ovf_cnt, overflow, short_err);
    end
    do_reset;
  endtask

  task automatic test_single_line;
    logic [12:0] exp;
    do_reset;
    m_ready = 1'b1;
    send_line(LP, 12'h000, 1'b0);
    n_checks++;
    if (m_valid !== 1'b0) begin n_fail++; $display("FAIL latency_n: m_valid=%b required 0", m_valid); end
    tick;
    n_checks++;
    if (m_valid !== 1'b0) begin n_fail++; $display("FAIL latency_n1: m_valid=%b required 0", m_valid); end
    tick;
    n_checks++;
    if (m_valid !== 1'b1) begin n_fail++; $display("FAIL latency_n2: m_valid=%b required 1", m_valid); end
    wait_beats(LP, 2000, "single_count");
    for (int i = 0; i < LP; i++) begin
      exp = {1'(i == LP - 1), 12'(i)};
      n_checks++;
      if (beats[i] !== exp) begin
        n_fail++;
        $display("FAIL single_beat[%0d]: got %h required %h", i, beats[i], exp);
      end
    end
    repeat (3) tick;
    n_checks++;
    if (line_cnt !== 16'd1) begin n_fail++; $display("FAIL single_line_cnt: got %0d required 1", line_cnt); end
    n_checks++;
    if (m_valid !== 1'b0) begin n_fail++; $display("FAIL single_idle: m_valid=%b required 0", m_valid); end
  endtask

  task automatic test_back_to_back;
    logic [12:0] prev, exp;
    bit prev_stall;
    do_reset;
    m_ready = 1'b0;
    send_line(LP, 12'h100, 1'b0);
    prev_stall = 1'b0;
    prev = '0;
    for (int c = 0; c < 4000 && beats.size() < LP; c++) begin
      if (prev_stall) begin
        n_checks++;
        if ({m_last, m_data} !== prev) begin
          n_fail++;
          $display("FAIL bp_stable: got %h required %h", {m_last, m_data}, prev);
        end
      end
      m_ready    = ~m_ready;
      prev_stall = m_valid && !m_ready;
      prev       = {m_last, m_data};
      tick;
    end
    m_ready = 1'b1;
    n_checks++;
    if (beats.size() != LP) begin n_fail++; $display("FAIL bp_count: got %0d required %0d", beats.size(), LP); end
    for (int i = 0; i < LP; i++) begin
      exp = {1'(i == LP - 1), 12'h100 + 12'(i)};
      n_checks++;
      if (beats[i] !== exp) begin n_fail++; $display("FAIL bp_beat[%0d]: got %h required %h", i, beats[i], exp); end
    end
    n_checks++;
    if (short_cnt != 0) begin n_fail++; $display("FAIL bp_short_err: got %0d pulses required 0", short_cnt); end
  endtask

  task automatic test_overflow;
    logic [12:0] exp;
    do_reset;
    m_ready = 1'b0;
    send_line(LP, 12'h100, 1'b0);
    send_line(LP, 12'h200, 1'b0);
    send_line(LP, 12'h400, 1'b0);
    tick;
    n_checks++;
    if (ovf_cnt !== 8'd1) begin n_fail++; $display("FAIL ovf_cnt: got %0d required 1", ovf_cnt); end
    n_checks++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b required 1", overflow); end
    n_checks++;
    if (m_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_stalled_valid: got %b required 1", m_valid); end
    m_ready = 1'b1;
    wait_beats(2 * LP, 3000, "ovf_count");
    repeat (20) tick;
    n_checks++;
    if (beats.size() != 2 * LP) begin n_fail++; $display("FAIL ovf_extra: got %0d beats required %0d", beats.size(), 2 * LP); end
    for (int i = 0; i < 2 * LP; i++) begin
      exp = {1'((i % LP) == LP - 1), ((i < LP) ? 12'h100 : 12'h200) + 12'(i % LP)};
      n_checks++;
      if (beats[i] !== exp) begin n_fail++; $display("FAIL ovf_beat[%0d]: got %h required %h", i, beats[i], exp); end
    end
    n_checks++;
    if (line_cnt !== 16'd2) begin n_fail++; $display("FAIL ovf_line_cnt: got %0d required 2", line_cnt); end
  endtask

  task automatic test_short_line;
    logic [12:0] exp;
    do_reset;
    m_ready = 1'b1;
    send_line(100, 12'h500, 1'b0);
    tick;
    send_line(LP, 12'h600, 1'b0);
    wait_beats(LP, 2000, "short_count");
    repeat (20) tick;
    n_checks++;
    if (short_cnt != 1) begin n_fail++; $display("FAIL short_err_pulses: got %0d required 1", short_cnt); end
    n_checks++;
    if (beats.size() != LP) begin n_fail++; $display("FAIL short_beats: got %0d required %0d", beats.size(), LP); end
    for (int i = 0; i < LP; i++) begin
      exp = {1'(i == LP - 1), 12'h600 + 12'(i)};
      n_checks++;
      if (beats[i] !== exp) begin n_fail++; $display("FAIL short_beat[%0d]: got %h required %h", i, beats[i], exp); end
    end
  endtask

  task automatic test_simultaneous;
    do_reset;
    m_ready = 1'b1;
    send_line(LP, 12'hABC, 1'b1);
    wait_beats(LP, 2000, "simul_count");
    n_checks++;
    if (beats[0] !== 13'h0ABC) begin n_fail++; $display("FAIL simul_beat0: got %h required 0abc", beats[0]); end
    n_checks++;
    if (beats[1] !== {1'b0, 12'hABC + 12'd1}) begin n_fail++; $display("FAIL simul_beat1: got %h required %h", beats[1], {1'b0, 12'hABD}); end
    n_checks++;
    if (beats[LP-1] !== {1'b1, 12'hABC + 12'(LP - 1)}) begin
      n_fail++; $display("FAIL simul_last: got %h required %h", beats[LP-1], {1'b1, 12'hABC + 12'(LP - 1)});
    end
  endtask

  task automatic test_bank_free_race;
    do_reset;
    m_ready = 1'b0;
    send_line(LP, 12'h000, 1'b0);
    send_line(LP, 12'h200, 1'b0);
    m_ready = 1'b1;
    repeat (LP - 1) tick;
    // The final beat of bank 0 is accepted on the same edge that samples line_start.
    line_start = 1'b1;
    tick;
    line_start = 1'b0;
    n_checks++;
    if (ovf_cnt !== 8'd0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL race_ovf: got cnt=%0d flag=%b required 0/0", ovf_cnt, overflow);
    end
    for (int i = 0; i < LP; i++) begin
      tick;
      wr = 1'b1; din = 12'h800 + 12'(i);
      tick;
      wr = 1'b0;
    end
    wait_beats(3 * LP, 3000, "race_count");
    repeat (5) tick;
    n_checks++;
    if (beats[LP-1] !== {1'b1, 12'h1FF}) begin n_fail++; $display("FAIL race_a_last: got %h required 11ff", beats[LP-1]); end
    n_checks++;
    if (beats[LP] !== {1'b0, 12'h200}) begin n_fail++; $display("FAIL race_b_first: got %h required 0200", beats[LP]); end
    n_checks++;
    if (beats[2*LP] !== {1'b0, 12'h800}) begin n_fail++; $display("FAIL race_c_first: got %h required 0800", beats[2*LP]); end
    n_checks++;
    if (beats[3*LP-1] !== {1'b1, 12'h9FF}) begin n_fail++; $display("FAIL race_c_last: got %h required 19ff", beats[3*LP-1]); end
    n_checks++;
    if (line_cnt !== 16'd3 || ovf_cnt !== 8'd0) begin
      n_fail++; $display("FAIL race_counters: got lc=%0d oc=%0d required 3/0", line_cnt, ovf_cnt);
    end
  endtask

  task automatic test_reset_mid_stream;
    logic [12:0] exp;
    do_reset;
    m_ready = 1'b1;
    send_line(LP, 12'h300, 1'b0);
    wait_beats(LP, 2000, "rst_first_line");
    send_line(LP, 12'h400, 1'b0);
    wait_beats(LP + 200, 2000, "rst_beat200");
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({m_valid, m_data, m_last} !== 14'd0) begin
      n_fail++; $display("FAIL rst_async_stream: got v=%b d=%h l=%b required 0", m_valid, m_data, m_last);
    end
    n_checks++;
    if (line_cnt !== 16'd0 || ovf_cnt !== 8'd0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL rst_async_counters: got lc=%0d oc=%0d of=%b required 0", line_cnt, ovf_cnt, overflow);
    end
    tick; tick;
    #2;
    reset = 1'b0;
    beats.delete();
    tick;
    for (int i = 0; i < LP; i++) begin
      wr = 1'b1; din = 12'h0F0;
      tick;
      wr = 1'b0;
      tick;
    end
    repeat (50) tick;
    n_checks++;
    if (beats.size() != 0) begin n_fail++; $display("FAIL rst_ignore_wr: got %0d beats required 0", beats.size()); end
    send_line(LP, 12'h500, 1'b0);
    wait_beats(LP, 2000, "rst_next_count");
    for (int i = 0; i < LP; i++) begin
      exp = {1'(i == LP - 1), 12'h500 + 12'(i)};
      n_checks++;
      if (beats[i] !== exp) begin n_fail++; $display("FAIL rst_next_beat[%0d]: got %h required %h", i, beats[i], exp); end
    end
  endtask

  initial begin
    test_reset;
    test_single_line;
    test_back_to_back;
    test_overflow;
    test_short_line;
    test_simultaneous;
    test_bank_free_race;
    test_reset_mid_stream;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pix_line_buffer.md
# pix_line_buffer

Ping-pong line buffer downstream of the 12-bit training/alignment stage. Captures each line of LINE_PIX pixels delivered on the aligner's `wr`/`dout` strobes and replays completed lines on a valid/ready stream with an end-of-line marker. The aligner has no back-pressure, so the block absorbs one line of output stall and drops whole lines, flagged, when both banks are occupied.

## Interface

Parameters:
- `LINE_PIX`, 512: pixels per line; power of two, 4..4096.
- `AW`, 9: address width; must equal log2(LINE_PIX).

Ports:
- `clk`  in  1  pixel-domain clock; same clock as the aligner.
- `reset`  in  1  asynchronous, active-high reset.
- `line_start`  in  1  single-cycle pulse from the aligner's `xhs` rising edge; opens a line.
- `wr`  in  1  pixel strobe from the aligner.
- `din`  in  12  pixel data, qualified by `wr`.
- `m_valid`  out  1  output beat valid.
- `m_ready`  in  1  consumer accepts the beat.
- `m_data`  out  12  output pixel.
- `m_last`  out  1  high on the final beat of a line (index LINE_PIX-1).
- `line_cnt`  out  16  lines fully emitted; wraps at 65535 to 0.
- `ovf_cnt`  out  8  lines dropped for lack of a free bank; saturates at 255.
- `overflow`  out  1  sticky; set on the first dropped line.
- `short_err`  out  1  one-cycle pulse when a partial line is discarded.

## Operation

- Two banks, each LINE_PIX×12 with registered read. Each bank is FREE or FULL; all banks are FREE at reset.
- Writer states:
  - WAIT: waits for the first `line_start`; `wr` is ignored.
  - FILL: writes to bank `wbank`.
  - DROP: discards pixels until the next `line_start`.
- On `line_start`:
  - If the writer is in FILL with `wptr`≠0, the partial line is discarded, `wptr` is set to 0 and `short_err` pulses.
  - If bank `wbank` is FREE, the writer enters FILL. A bank being freed by the reader in the same cycle counts as FREE.
  - Otherwise the writer enters DROP, `ovf_cnt` increments (saturating) and `overflow` is set.
- In FILL, each `wr` stores `din` at address `wptr`, then `wptr` increments.
  - When a write lands at LINE_PIX-1, the bank is marked FULL, `wbank` toggles and the writer enters WAIT.
  - Pixels after the line is complete and before the next `line_start` are ignored.
- `line_start` and `wr` in the same cycle: the `line_start` action happens first, then the pixel is written at address 0 and `wptr` becomes 1 (FILL case only).
- Reader states: IDLE, PREFETCH and STREAM.
  - IDLE: when bank `rbank` is FULL, the reader enters PREFETCH and issues a read at address 0.
  - STREAM: each accepted beat (`m_valid & m_ready`) advances `rptr`, and the next word is prefetched so there are no bubbles under continuous `m_ready`.
  - After the LINE_PIX-1 beat is accepted: the bank becomes FREE, `rbank` toggles, `line_cnt` increments, and the reader returns to IDLE. It can start the other bank on the next cycle if that bank is FULL.
- Stream rules:
  - `m_data` and `m_last` hold stable while `m_valid & ~m_ready`.
  - `m_valid` never drops before the beat is accepted.
- Counters and flags are cleared only by `reset`.

## Timing

- Values after reset, and asynchronously while `reset` is high: `m_valid`, `m_data`, `m_last`, `line_cnt`, `ovf_cnt`, `overflow`, `short_err` are all 0. `wptr`/`rptr`/`wbank`/`rbank` are 0, both banks FREE, writer WAIT, reader IDLE.
- Latency: with the reader idle, `m_valid` rises at the second rising edge after the edge that captured pixel LINE_PIX-1.
  - Edge N: the last pixel is written and the bank goes FULL.
  - N+1: PREFETCH.
  - N+2: `m_valid` is high.
- Throughput: one beat per cycle while `m_ready` is high. The input rate is at most one pixel every two cycles, so a line drains in less than one line time.
- Reset mid-line discards all buffered data; the writer must see a new `line_start` before capturing again.

## Configuration

- `PIX_TEST_PATTERN_EN` defined: the writer stores `{ {12-AW}'b0, wptr }` instead of `din`. Output beat k of every line equals k. Everything else is unchanged; this is for bring-up without a sensor.
- Not defined: `din` is stored and replayed verbatim.

## Test plan

- Single line, `m_ready`=1: `line_start`, then 512 writes `din`=i. Beats 0..511 carry values 0..511. `m_last` is high only on beat 511. `m_valid` rises 2 cycles after the last write. `line_cnt`=1.
- Back-pressure: toggle `m_ready` 1/0 every cycle. All 512 beats arrive in order, with data stable during each stall. No `short_err`.
- Overflow: `m_ready`=0 while three full lines are sent. Lines 1 and 2 are buffered and line 3 is dropped: `ovf_cnt`=1, `overflow`=1. When `m_ready` is released, exactly lines 1 and 2 are emitted. `line_cnt`=2.
- Short line: `line_start`, 100 writes, then `line_start`. `short_err` pulses once. The next full line is emitted from pixel 0 with 512 beats.
- Simultaneous events:
  - `line_start` and `wr`(`din`=0xABC) in the same cycle: beat 0 = 0xABC.
  - Bank freed in the cycle `line_start` checks it: the line is accepted and `ovf_cnt` is unchanged.
- Reset mid-stream: assert `reset` at beat 200. `m_valid` is 0 immediately and the counters are 0. Pixels without a new `line_start` are ignored. The next line after a new `line_start` emits correctly.
